// File: rtl/uart_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_alu_ctrl
// Brief    : Frames received UART bytes into {opcode, A, B} commands, runs
//            them through an 8-bit ALU with a 16-bit result and returns the
//            result high byte first through the transmitter start/busy
//            handshake. Flags invalid opcodes, timed-out partial frames and
//            bytes that arrive while a command is still being serviced.
// Revision : 1.0 - initial release
// ============================================================================
module uart_alu_ctrl #(
    parameter int DATA_LENGTH   = 8,
    parameter int TIMEOUT       = 500000,
    parameter int TIMEOUT_WIDTH = $clog2(TIMEOUT + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_LENGTH-1:0]     rx_data,
    input  logic                       rx_done,
    input  logic                       tx_busy,
    output logic                       tx_start,
    output logic [DATA_LENGTH-1:0]     tx_data,
    output logic [2*DATA_LENGTH-1:0]   result,
    output logic                       err,
    output logic                       frame_drop,
    output logic                       overrun,
    output logic                       busy
);

    localparam logic [DATA_LENGTH-1:0]   c_OP_ADD     = DATA_LENGTH'(0);
    localparam logic [DATA_LENGTH-1:0]   c_OP_SUB     = DATA_LENGTH'(1);
    localparam logic [DATA_LENGTH-1:0]   c_OP_AND     = DATA_LENGTH'(2);
    localparam logic [DATA_LENGTH-1:0]   c_OP_OR      = DATA_LENGTH'(3);
    localparam logic [DATA_LENGTH-1:0]   c_OP_XOR     = DATA_LENGTH'(4);
    localparam logic [DATA_LENGTH-1:0]   c_OP_MUL     = DATA_LENGTH'(5);
    localparam logic [2*DATA_LENGTH-1:0] c_ERR_RESULT = {(DATA_LENGTH/2){4'hE}};
    localparam logic [TIMEOUT_WIDTH-1:0] c_TIMEOUT    = TIMEOUT_WIDTH'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_GET_OP  = 3'd0,
        ST_GET_A   = 3'd1,
        ST_GET_B   = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND_HI = 3'd4,
        ST_WAIT_HI = 3'd5,
        ST_SEND_LO = 3'd6,
        ST_WAIT_LO = 3'd7
    } state_t;

    state_t                     r_state;
    state_t                     w_next;

    logic                       r_rx_done_q;
    logic                       w_accept;
    logic [DATA_LENGTH-1:0]     r_op;
    logic [DATA_LENGTH-1:0]     r_a;
    logic [DATA_LENGTH-1:0]     r_b;
    logic [2*DATA_LENGTH-1:0]   r_result;
    logic [TIMEOUT_WIDTH-1:0]   r_cnt;
    logic                       r_wait_first;
    logic                       r_err;
    logic                       r_frame_drop;
    logic                       r_overrun;

    logic                       w_counting;
    logic                       w_timeout;
    logic                       w_in_service;
    logic [DATA_LENGTH:0]       w_sum;
    logic [DATA_LENGTH:0]       w_diff;
    logic [2*DATA_LENGTH-1:0]   w_alu;
    logic                       w_alu_err;
    logic                       w_tx_start;
    logic [DATA_LENGTH-1:0]     w_tx_data;

    // A byte is taken only on the rising edge of the multi-cycle done level;
    // the delayed copy resets high so a level already present is ignored.
    assign w_accept     = rx_done && !r_rx_done_q;
    assign w_counting   = (r_state == ST_GET_A) || (r_state == ST_GET_B);
    // A byte landing on the expiry cycle wins over the drop.
    assign w_timeout    = w_counting && (r_cnt == c_TIMEOUT) && !w_accept;
    assign w_in_service = !(r_state == ST_GET_OP || w_counting);
    assign w_sum        = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff       = {1'b0, r_a} - {1'b0, r_b};

    // ALU: combinational evaluation of the latched frame, registered in EXEC.
    always_comb begin
        w_alu     = '0;
        w_alu_err = 1'b0;
        case (r_op)
            c_OP_ADD: w_alu = {{(DATA_LENGTH-1){1'b0}}, w_sum};
            c_OP_SUB: w_alu = {{(DATA_LENGTH-1){w_diff[DATA_LENGTH]}}, w_diff};
            c_OP_AND: w_alu = {{DATA_LENGTH{1'b0}}, r_a & r_b};
            c_OP_OR:  w_alu = {{DATA_LENGTH{1'b0}}, r_a | r_b};
            c_OP_XOR: w_alu = {{DATA_LENGTH{1'b0}}, r_a ^ r_b};
            c_OP_MUL: w_alu = {{DATA_LENGTH{1'b0}}, r_a} * {{DATA_LENGTH{1'b0}}, r_b};
            default: begin
                w_alu     = c_ERR_RESULT;
                w_alu_err = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_GET_OP;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic plus the transmitter request and byte select.
    always_comb begin
        w_next     = r_state;
        w_tx_start = 1'b0;
        w_tx_data  = '0;
        case (r_state)
            ST_GET_OP: begin
                if (w_accept) w_next = ST_GET_A;
            end
            ST_GET_A: begin
                if (w_accept)       w_next = ST_GET_B;
                else if (w_timeout) w_next = ST_GET_OP;
            end
            ST_GET_B: begin
                if (w_accept)       w_next = ST_EXEC;
                else if (w_timeout) w_next = ST_GET_OP;
            end
            ST_EXEC: begin
                w_next = ST_SEND_HI;
            end
            ST_SEND_HI: begin
                w_tx_data  = r_result[2*DATA_LENGTH-1:DATA_LENGTH];
                w_tx_start = !tx_busy;
                if (!tx_busy) w_next = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                // tx_busy only rises one cycle after the request, so the
                // first waiting cycle must not be trusted.
                w_tx_data = r_result[2*DATA_LENGTH-1:DATA_LENGTH];
                if (!r_wait_first && !tx_busy) w_next = ST_SEND_LO;
            end
            ST_SEND_LO: begin
                w_tx_data  = r_result[DATA_LENGTH-1:0];
                w_tx_start = !tx_busy;
                if (!tx_busy) w_next = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                w_tx_data = r_result[DATA_LENGTH-1:0];
                if (!r_wait_first && !tx_busy) w_next = ST_GET_OP;
            end
            default: begin
                w_next = ST_GET_OP;
            end
        endcase
    end

    // Datapath: edge detect, frame capture, timeout counter, result and pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_done_q  <= 1'b1;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_result     <= '0;
            r_cnt        <= '0;
            r_wait_first <= 1'b0;
            r_err        <= 1'b0;
            r_frame_drop <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_rx_done_q <= rx_done;
            if (w_accept && r_state == ST_GET_OP) r_op <= rx_data;
            if (w_accept && r_state == ST_GET_A)  r_a  <= rx_data;
            if (w_accept && r_state == ST_GET_B)  r_b  <= rx_data;
            if (!w_counting || w_accept || w_timeout) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + TIMEOUT_WIDTH'(1);
            end
            if (r_state == ST_EXEC) r_result <= w_alu;
            r_wait_first <= w_tx_start;
            r_err        <= (r_state == ST_EXEC) && w_alu_err;
            r_frame_drop <= w_timeout;
            r_overrun    <= w_accept && w_in_service;
        end
    end

    assign tx_start   = w_tx_start;
    assign tx_data    = w_tx_data;
    assign result     = r_result;
    assign err        = r_err;
    assign frame_drop = r_frame_drop;
    assign overrun    = r_overrun;
    assign busy       = (r_state != ST_GET_OP);

endmodule
`default_nettype wire

// File: doc/uart_alu_ctrl.md
# uart_alu_ctrl

Command parser and executor that sits directly downstream of the UART receiver and upstream of the UART transmitter in the UART-ALU datapath. It captures received bytes on the rising edge of the receiver's multi-cycle `done` level and assembles three-byte frames: opcode, operand A, operand B. It executes the frame in an internal 8-bit ALU with a 16-bit result, then returns the result as two bytes, high byte first, through a start/busy handshake with the transmitter.

## Interface
- `DATA_LENGTH`, 8 — byte width; ALU operands are `DATA_LENGTH`, result is `2*DATA_LENGTH`.
- `TIMEOUT`, 500000 — maximum idle clock cycles allowed between bytes of one frame.
- `TIMEOUT_WIDTH`, `$clog2(TIMEOUT+1)` — width of the inter-byte timeout counter.

Ports:
- `clk` input 1 — single clock.
- `rst` input 1 — reset; synchronous, active-high.
- `rx_data` input `DATA_LENGTH` — received byte; stable while `rx_done` is high.
- `rx_done` input 1 — receiver done level; high for several cycles per byte.
- `tx_busy` input 1 — transmitter busy.
- `tx_start` output 1 — one-cycle request to send `tx_data`.
- `tx_data` output `DATA_LENGTH` — byte to transmit.
- `result` output `2*DATA_LENGTH` — last computed result, held until the next EXEC.
- `err` output 1 — one-cycle pulse when the opcode is invalid.
- `frame_drop` output 1 — one-cycle pulse when a partial frame is discarded on timeout.
- `overrun` output 1 — one-cycle pulse when a byte arrives while busy and is dropped.
- `busy` output 1 — high in every state except GET_OP.

## Operation
- **Byte accept.** `rx_done_q` registers `rx_done` and resets to 1. A byte is accepted on the cycle where `rx_done && !rx_done_q`. `rx_data` is sampled in that same cycle. Because `rx_done_q` resets to 1, a `rx_done` level already high when reset deasserts is not accepted.
- **FSM states:** GET_OP, GET_A, GET_B, EXEC, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO.
  - GET_OP: on accept, latch opcode, go to GET_A.
  - GET_A: on accept, latch A, go to GET_B.
  - GET_B: on accept, latch B, go to EXEC.
  - EXEC: one cycle; register `result`; pulse `err` if invalid; go to SEND_HI.
  - SEND_HI: `tx_start` = !`tx_busy`, `tx_data` = `result[15:8]`. Leave for WAIT_HI on the cycle `tx_start` is high.
  - WAIT_HI: ignore `tx_busy` on the first cycle. Afterwards, go to SEND_LO when `tx_busy`==0.
  - SEND_LO and WAIT_LO: same as the HI pair with `result[7:0]`. WAIT_LO returns to GET_OP.
- **Transmitter contract.** `tx_busy` rises the cycle after `tx_start` and stays high until the byte is finished. `tx_data` holds its value from SEND_x through WAIT_x.
- **Opcodes.** Results are 16 bits:
  - 0x00 ADD: {7'b0, A+B} (9-bit sum, zero-extended).
  - 0x01 SUB: A−B sign-extended to 16 bits, two's complement.
  - 0x02 AND, 0x03 OR, 0x04 XOR: zero-extended.
  - 0x05 MUL: full 16-bit unsigned product.
  - Any other opcode: `result` = 16'hEEEE and `err` pulses. The result bytes are still sent.
- **Timeout.** The counter runs only in GET_A and GET_B and clears on every accept. When it reaches `TIMEOUT`: pulse `frame_drop`, return to GET_OP, leave `result` unchanged.
- **Overrun.** An accept in any state from EXEC through WAIT_LO pulses `overrun`, and the byte is dropped. Framing restarts at GET_OP.
- **Simultaneous events.** An accept in the same cycle the timeout reaches `TIMEOUT` wins: the byte is taken and no drop occurs.
- **Reset.** A reset mid-frame or mid-send abandons all work. Any `tx_start` is withdrawn in the next cycle.

## Timing
- **Reset values:**
  - FSM = GET_OP.
  - `tx_start`=0, `tx_data`=0, `result`=0.
  - `err`=0, `frame_drop`=0, `overrun`=0, `busy`=0.
  - Timeout counter = 0, `rx_done_q`=1.
- **Pipeline.** Let cycle N be the third-byte accept.
  - N+1: EXEC.
  - N+2: `result` valid, `err` pulse, state SEND_HI.
  - `tx_start` is high at N+2 if `tx_busy`=0.
- `tx_start` is never high on two consecutive cycles.
- `err`, `frame_drop` and `overrun` are each exactly one cycle wide.

## Test plan
- ADD: frame 0x00,0xFF,0x01 → `result`=0x0100; sends 0x01 then 0x00.
- SUB/MUL: frame 0x01,0x03,0x05 → `result`=0xFFFE, sends 0xFF then 0xFE. Frame 0x05,0xFF,0xFF → sends 0xFE then 0x01.
- Invalid opcode: frame 0x07,0x11,0x22 → `err` pulses one cycle in EXEC; sends 0xEE, 0xEE.
- Timeout: send 0x00,0x12, then idle for `TIMEOUT`+1 cycles → `frame_drop` pulses once. A following frame 0x04,0x0F,0xF0 then sends 0x00,0xFF.
- Overrun and handshake: hold `tx_busy` high 20 cycles; inject a byte during WAIT_HI → `overrun` pulse, byte dropped, exactly two `tx_start` pulses total.
- Reset with `rx_done` high: hold `rx_done`=1 across `rst` deassertion → no byte accepted. After reset, a mid-frame `rst` returns to GET_OP with all outputs at reset values.
